// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver feeding a first-word-fall-through FIFO with valid/ready output.
// Reports stop-bit framing errors and sticky FIFO overflow.
module uart_rx_fifo #(
    parameter int unsigned CLK_FREQ   = 60000000,
    parameter int unsigned BAUDRATE   = 1000000,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         rx_i,
    output logic [7:0]                   data_o,
    output logic                         valid_o,
    input  logic                         ready_i,
    output logic [$clog2(FIFO_DEPTH):0]  level_o,
    output logic                         frame_err_o,
    output logic                         overflow_o,
    input  logic                         clear_i
);

    localparam int unsigned DIV  = CLK_FREQ / BAUDRATE;
    localparam int unsigned HALF = DIV / 2;
    localparam int unsigned AW   = $clog2(FIFO_DEPTH);
    localparam int unsigned CW   = $clog2(DIV);

    localparam logic [CW-1:0] CNT_FULL = CW'(DIV - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);
    localparam logic [AW:0]   LVL_FULL = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StBreak} state_e;

    state_e          r_state;
    state_e          w_state_d;
    logic            r_rx_meta;
    logic            r_rx_s;
    logic [CW-1:0]   r_cnt;
    logic [2:0]      r_bit_idx;
    logic [7:0]      r_shift;
    logic            w_cnt_zero;
    logic            w_sample_ok;
    logic            w_sample_bad;
    logic            r_push;
    logic            r_frame_err;
    logic [7:0]      r_mem [FIFO_DEPTH];
    logic [AW:0]     r_wr_ptr;
    logic [AW:0]     r_rd_ptr;
    logic [AW:0]     w_level;
    logic            w_full;
    logic            w_pop;
    logic            w_push_ok;
    logic            w_drop;
    logic            r_overflow;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= rx_i;
            r_rx_s    <= r_rx_meta;
        end
    end

    assign w_cnt_zero = (r_cnt == '0);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        case (r_state)
            StIdle:  if (!r_rx_s) w_state_d = StStart;
            StStart: if (w_cnt_zero) w_state_d = r_rx_s ? StIdle : StData;
            StData:  if (w_cnt_zero && (r_bit_idx == 3'd7)) w_state_d = StStop;
            StStop:  if (w_cnt_zero) w_state_d = r_rx_s ? StIdle : StBreak;
            StBreak: if (r_rx_s) w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
    end

    always_comb begin
        w_sample_ok  = 1'b0;
        w_sample_bad = 1'b0;
        if ((r_state == StStop) && w_cnt_zero) begin
            w_sample_ok  = r_rx_s;
            w_sample_bad = ~r_rx_s;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (!r_rx_s) r_cnt <= CNT_HALF;
                end
                StStart: begin
                    if (w_cnt_zero) begin
                        r_cnt     <= CNT_FULL;
                        r_bit_idx <= '0;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                StData: begin
                    if (w_cnt_zero) begin
                        r_shift[r_bit_idx] <= r_rx_s;
                        r_bit_idx          <= r_bit_idx + 3'd1;
                        r_cnt              <= CNT_FULL;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                StStop: begin
                    if (!w_cnt_zero) r_cnt <= r_cnt - 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Push and error are registered one cycle after the stop-bit sample; r_shift is
    // stable in that cycle because only StData modifies it.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_push      <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_push      <= w_sample_ok;
            r_frame_err <= w_sample_bad;
        end
    end

    assign w_level   = r_wr_ptr - r_rd_ptr;
    assign w_full    = (w_level == LVL_FULL);
    assign valid_o   = (w_level != '0);
    assign w_pop     = valid_o & ready_i;
    assign w_push_ok = r_push & (~w_full | w_pop);
    assign w_drop    = r_push & w_full & ~w_pop;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) r_mem[i] <= '0;
        end else if (w_push_ok) begin
            r_mem[r_wr_ptr[AW-1:0]] <= r_shift;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)     r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Set has priority over clear.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (clear_i) begin
            r_overflow <= 1'b0;
        end
    end

    assign data_o      = r_mem[r_rd_ptr[AW-1:0]];
    assign level_o     = w_level;
    assign frame_err_o = r_frame_err;
    assign overflow_o  = r_overflow;

endmodule
